// File: rtl/encoder_priority_hold.sv
// Sequential priority encoder: sticky pending requests, highest index presented
// with a valid/ack handshake and held stable until acknowledged.
module encoder_priority_hold #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [N-1:0] in_i,
  input  logic         ack_i,
  output logic [W-1:0] out_o,
  output logic         valid_o,
  output logic [N-1:0] pending_o,
  output logic         dup_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   pending_q;
  logic [W-1:0]   out_q;
  logic           valid_q;
  logic           dup_q;

  logic [N-1:0]   cap_d;
  logic           take_d;
  logic [N-1:0]   clr_d;
  logic [N-1:0]   pending_d;
  logic           dup_d;

  // Highest set index; an empty vector encodes as 0.
  function automatic logic [W-1:0] prio(input logic [N-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        r = i[W-1:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Next pending set: the served bit is cleared, but a same-cycle capture wins.
  always_comb begin
    cap_d     = en_i ? in_i : '0;
    take_d    = valid_q & ack_i;
    clr_d     = take_d ? onehot(out_q) : '0;
    pending_d = (pending_q & ~clr_d) | cap_d;
    dup_d     = |(cap_d & pending_q & ~clr_d);
  end

  // Pending register, duplicate pulse and the present/hold handshake FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      dup_q     <= dup_d;
      case (state_q)
        ST_IDLE: begin
          if (|pending_d) begin
            state_q <= ST_PRESENT;
            valid_q <= 1'b1;
            out_q   <= prio(pending_d);
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            out_q   <= '0;
          end
        end
        ST_PRESENT: begin
          // Later higher-priority captures never preempt the held index.
          if (!ack_i) begin
            state_q <= ST_PRESENT;
            valid_q <= 1'b1;
            out_q   <= out_q;
          end else if (|pending_d) begin
            state_q <= ST_PRESENT;
            valid_q <= 1'b1;
            out_q   <= prio(pending_d);
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            out_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          out_q   <= '0;
        end
      endcase
    end
  end

  assign out_o     = out_q;
  assign valid_o   = valid_q;
  assign pending_o = pending_q;
  assign dup_o     = dup_q;

endmodule

// File: doc/encoder_priority_hold.md
# encoder_priority_hold

Sequential N-to-log2(N) priority encoder. It is the encoding counterpart of the team's 2-to-4 enable decoder. Enabled request lines are captured into a sticky pending register. The block presents the index of the highest-numbered pending request with a valid/ack handshake, and holds that index stable until the consumer acknowledges it. It sits between request sources, such as interrupt lines or per-lane events, and a consumer that decodes the index back to a one-hot select.

## Interface
- N, default 4: number of request lines; must be ≥ 2 and a power of 2.
- W, default 2: index width; must equal log2(N).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  capture enable; when 0, the in bits are ignored.
- in  input  N  request lines; bit i requests index i; sampled every cycle that en=1.
- ack  input  1  consumer accepts the presented index; ignored while valid=0.
- out  output  W  presented index, bit i of in maps to index i; registered.
- valid  output  1  out holds a pending request; registered.
- pending  output  N  current pending register, for visibility.
- dup  output  1  one-cycle pulse: a request arrived for an index already pending and not being cleared.

## Operation
- Define the following terms for each cycle.
  - cap = en ? in : 0.
  - take = valid & ack.
  - clr = take ? onehot(out) : 0.
  - pn = (pending & ~clr) | cap. Capture wins when set and clear hit the same bit in the same cycle.
- Every rising edge (rst_n=1): pending <= pn.
- Handshake FSM, with valid acting as the state bit:
  - IDLE (valid=0): {valid, out} <= {|pn, prio(pn)}. IDLE→PRESENT when pn≠0.
  - PRESENT (valid=1, ack=0): out and valid hold. Newly captured higher-priority requests do NOT preempt the presented index.
  - PRESENT with ack=1: {valid, out} <= {|pn, prio(pn)}. This allows back-to-back presentation; PRESENT→IDLE only when pn=0.
- prio(x) = the highest index i with x[i]=1; prio(0)=0.
- When valid=0, out is 0.
- dup <= |(cap & pending & ~clr).
- ack with valid=0 has no effect.
- en=0 does not stop service of requests already pending.

## Timing
- Reset (rst_n=0 at an edge): pending=0, valid=0, out=0, dup=0. This overrides all inputs, including in, en and ack. Reset mid-handshake discards all pending requests; no ack is required afterwards.
- First cycle with rst_n=1 after reset behaves as IDLE with pending=0.
- Capture-to-valid latency: a request with en=1 before edge k gives pending[i]=1 and valid=1 with out=i after edge k, when the block was IDLE.
- Ack-to-next latency: ack sampled at edge k clears the served bit, and presents the next index (or drops valid) after that same edge. Throughput is 1 grant per cycle.
- Requests arriving in the ack cycle are included in the next selection.
- dup is asserted the cycle after the offending capture edge, for exactly 1 cycle per offending edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n=0 for 2 edges with in=4'b1111, en=1, ack=1 -> pending=0000, valid=0, out=0, dup=0; first edge after release with in=0 keeps everything 0.
- Single request: in=4'b0100, en=1 for 1 cycle -> after that edge pending=0100, valid=1, out=2; ack=1 for 1 cycle -> pending=0000, valid=0, out=0.
- Multi-hot, back-to-back: in=4'b1010 for 1 cycle -> out=3, valid=1; ack -> out=1, valid stays 1, pending=0010; ack -> valid=0, pending=0000.
- No preemption and enable gating:
  - Present out=0 (pending=0001), then in=4'b1000, en=1 -> out stays 0 while ack=0; ack -> out=3.
  - Separately, in=4'b1111 with en=0 -> pending and valid unchanged.
- Duplicate and capture-wins:
  - pending=0010, out=1, in=4'b0010, en=1, ack=0 -> dup=1 for one cycle, pending=0010.
  - Same stimulus with ack=1 -> dup=0, pending=0010, valid=1, out=1.
- Reset mid-handshake: valid=1, out=3, pending=1001, then rst_n=0 for 1 edge -> valid=0, out=0, pending=0000; ack after release ignored.
